// File: rtl/pool_seq_ctrl_if.sv
// Control bundle between a pooling-lane sequencer and its host/pooling unit.
// The slave modport is the sequencer side and the master modport is the driving side.
interface pool_seq_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DIM_W  = 7
);
  logic              start;
  logic [DIM_W-1:0]  cfg_width;
  logic [DIM_W-1:0]  cfg_height;
  logic              cfg_avg;
  logic              in_valid;
  logic              mux_sel;
  logic              wr_tmp;
  logic              wr_line;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              pool_op;
  logic              out_valid;
  logic              busy;
  logic              pool_done;
  logic              cfg_err;

  modport master (
    output start, cfg_width, cfg_height, cfg_avg, in_valid,
    input  mux_sel, wr_tmp, wr_line, rd_addr, wr_addr, pool_op,
           out_valid, busy, pool_done, cfg_err
  );

  modport slave (
    input  start, cfg_width, cfg_height, cfg_avg, in_valid,
    output mux_sel, wr_tmp, wr_line, rd_addr, wr_addr, pool_op,
           out_valid, busy, pool_done, cfg_err
  );
endinterface

// File: rtl/pool_seq_ctrl.sv
// Raster-order sequencer for one 2x2/stride-2 pooling lane group.
// Define POOL_AVG_EN to let cfg_avg select average pooling; otherwise pool_op is tied to max.
module pool_seq_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DIM_W  = 7
) (
  input  logic           clk,
  input  logic           nrst,
  pool_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int MAX_W = 1 << (ADDR_W + 1);

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic              s2_pend_q, s2_pend_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;

  logic              mux_sel_q, mux_sel_d;
  logic              wr_tmp_q, wr_tmp_d;
  logic              wr_line_q, wr_line_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              pool_op_q, pool_op_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              pool_done_q, pool_done_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_legal;
  logic              pix;
  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] half_col;

  assign cfg_legal = !bus.cfg_width[0] && !bus.cfg_height[0]
                  && (bus.cfg_width  >= DIM_W'(2))
                  && (bus.cfg_height >= DIM_W'(2))
                  && (int'(bus.cfg_width) <= MAX_W);
  assign pix      = (state_q == RUN) && bus.in_valid;
  assign last_col = (col_q == width_q  - DIM_W'(1));
  assign last_row = (row_q == height_q - DIM_W'(1));
  // Legal widths keep col>>1 inside the line buffer, so the top col bits are never needed here.
  assign half_col = col_q[ADDR_W:1];

`ifdef POOL_AVG_EN
  logic avg_q, avg_d;
`endif

  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    col_d       = col_q;
    row_d       = row_q;
    s2_pend_d   = 1'b0;
    s2_addr_d   = '0;
    mux_sel_d   = 1'b0;
    wr_tmp_d    = 1'b0;
    wr_line_d   = 1'b0;
    rd_addr_d   = '0;
    wr_addr_d   = '0;
    out_valid_d = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (cfg_legal) begin
            state_d  = RUN;
            width_d  = bus.cfg_width;
            height_d = bus.cfg_height;
            col_d    = '0;
            row_d    = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
            if (last_row) state_d = DRAIN;
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Stage 1: even columns park in temp, odd columns combine with it.
    if (pix) begin
      if (!col_q[0]) begin
        wr_tmp_d = 1'b1;
      end else begin
        mux_sel_d = 1'b1;
        if (!row_q[0]) begin
          wr_line_d = 1'b1;
          wr_addr_d = half_col;
        end else begin
          s2_pend_d = 1'b1;
          s2_addr_d = half_col;
        end
      end
    end

    // Stage 2 overlaps the next even pixel's temp write, so mux_sel stays 0 for it.
    if (s2_pend_q) begin
      out_valid_d = 1'b1;
      rd_addr_d   = s2_addr_q;
    end

    pool_done_d = (state_q == DRAIN);
    busy_d      = (state_d != IDLE) || pool_done_d;

`ifdef POOL_AVG_EN
    avg_d     = (state_q == IDLE && bus.start && cfg_legal) ? bus.cfg_avg : avg_q;
    pool_op_d = busy_d && avg_d;
`else
    pool_op_d = 1'b0;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      s2_pend_q   <= 1'b0;
      s2_addr_q   <= '0;
      mux_sel_q   <= 1'b0;
      wr_tmp_q    <= 1'b0;
      wr_line_q   <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      pool_op_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      pool_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      s2_pend_q   <= s2_pend_d;
      s2_addr_q   <= s2_addr_d;
      mux_sel_q   <= mux_sel_d;
      wr_tmp_q    <= wr_tmp_d;
      wr_line_q   <= wr_line_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      pool_op_q   <= pool_op_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      pool_done_q <= pool_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

`ifdef POOL_AVG_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) avg_q <= 1'b0;
    else       avg_q <= avg_d;
  end
`endif

  assign bus.mux_sel   = mux_sel_q;
  assign bus.wr_tmp    = wr_tmp_q;
  assign bus.wr_line   = wr_line_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.pool_op   = pool_op_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.pool_done = pool_done_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: doc/pool_seq_ctrl.md
# pool_seq_ctrl

Sequencer for one 2x2/stride-2 pooling lane group. It counts pixels streamed from the systolic-array output in raster order and drives the per-lane control vector: mux select, temp/line register-file writes, read/write addresses, operation select and result-valid. It sits where the lane-0 pooling controller sits. Its outputs feed the first pooling unit directly, and the per-lane pipeline latches skew them to the remaining lanes.

## Interface
- ADDR_W, 5: line-buffer address width; max feature-map width = 2^(ADDR_W+1)
- DIM_W, 7: width of the height/width configuration fields
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- start  in  1  begin a feature map; sampled only in IDLE
- cfg_width  in  DIM_W  feature-map width W, sampled with start
- cfg_height  in  DIM_W  feature-map height H, sampled with start
- cfg_avg  in  1  0 = max, 1 = average; sampled with start
- in_valid  in  1  one pixel per lane presented on sys_out this cycle
- mux_sel  out  1  1: pooling in1 = sys_out; 0: in1 = previous pooling result
- wr_tmp  out  1  write sys_out to temp register (addr 0)
- wr_line  out  1  write pooling_out to line buffer at wr_addr
- rd_addr  out  ADDR_W  line-buffer read address
- wr_addr  out  ADDR_W  line-buffer write address
- pool_op  out  1  operation select to max_avg_pooling
- out_valid  out  1  pooling_out holds a final 2x2 result
- busy  out  1  map in progress
- pool_done  out  1  one-cycle pulse, with the last out_valid
- cfg_err  out  1  one-cycle pulse, start rejected

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start when the config is legal: W and H even, both >= 2, W <= 2^(ADDR_W+1). Latches W, H, cfg_avg and clears the counters col = 0, row = 0.
- Illegal config: stay in IDLE and pulse cfg_err.
- Starts seen in RUN or DRAIN are ignored. in_valid is ignored in IDLE.
- Each in_valid in RUN, pixel (row, col), issues:
  - col even: wr_tmp.
  - col odd, row even: stage-1 combine (mux_sel = 1, sys_out with temp), wr_line at wr_addr = col>>1.
  - col odd, row odd: stage-1 combine, then stage-2 on the next cycle (mux_sel = 0, rd_addr = col>>1) with out_valid.
- Counters: col increments on every in_valid and wraps W-1 -> 0; row increments on the wrap.
- After the pixel at (H-1, W-1), go RUN -> DRAIN. DRAIN lasts one cycle, covering stage 2. Then go to IDLE.
- pool_op = latched cfg_avg; see Configuration.
- Line-buffer address arithmetic is the ADDR_W-bit value col>>1 and never wraps inside a legal map.

## Timing
- All outputs are registered. Reset value is 0 for every output, the counters and the state (IDLE).
- Pixel sampled at edge t:
  - wr_tmp / stage-1 controls valid in cycle t+1 (aligned with the lane's registered sys_out).
  - stage-2 controls and out_valid in cycle t+2.
- Back-to-back in_valid is sustained with no stall:
  - The stage-2 of an odd-column pixel overlaps the next even-column pixel's wr_tmp.
  - Those two never share the pooling unit, so mux_sel is 0 in that cycle.
- busy: rises the cycle after an accepted start and falls the cycle after pool_done.
- pool_done: coincides with the final out_valid.
- cfg_err: asserts the cycle after the rejected start.
- Gaps in in_valid simply hold the counters and keep the controls at 0.
- nrst asserted mid-map: immediate return to IDLE with all outputs at 0. A partial map is discarded.

## Configuration
- POOL_AVG_EN defined: pool_op follows the latched cfg_avg for the whole map.
- POOL_AVG_EN undefined: pool_op is constant 0 (max only). cfg_avg is ignored, and start with cfg_avg = 1 is still accepted.

## Test plan
- W = 4, H = 4, max, continuous in_valid for 16 cycles:
  - 16 pixels give wr_tmp x8, wr_line x4 at addrs 0,1,0,1 (rows 0 and 2).
  - out_valid x4, 2 cycles after pixels 5(?) ... specifically after pixels (1,1), (1,3), (3,1), (3,3).
  - pool_done coincides with the 4th out_valid; busy drops one cycle later.
- W = 4, H = 2 with a gap after every pixel: same control sequence, stretched. No out_valid without a preceding odd-row, odd-col pixel.
- start with W = 3, H = 4: cfg_err pulses once, busy stays 0. Start with W = 2^(ADDR_W+1)+2: cfg_err.
- start asserted in RUN with a different W: ignored, and the original map completes with the original counts.
- nrst pulled low after pixel 6 of a 4x4 map: all outputs 0 immediately. A new 2x2 map then yields exactly one out_valid, with pool_done.
- cfg_avg = 1: pool_op = 1 for the whole map with POOL_AVG_EN defined; pool_op = 0 with it undefined.
